// File: rtl/risc16_pkg.sv
// Shared constants and writeback entry type for the 16-bit core.
package risc16_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
    logic              is_load;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU results, load issue/response handshakes, regfile write port.
interface wb_arbiter_if;
  import risc16_pkg::*;

  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_dest;
  logic [DATA_W-1:0]   alu_data;
  logic                ld_issue;
  logic [ADDR_W-1:0]   ld_issue_dest;
  logic                ld_issue_ready;
  logic                ld_rsp_valid;
  logic [DATA_W-1:0]   ld_rsp_data;
  logic                ld_rsp_ready;
  logic                reg_write_en;
  logic [ADDR_W-1:0]   reg_write_dest;
  logic [DATA_W-1:0]   reg_write_data;
  logic [NUM_REGS-1:0] pending;
  logic                waw_err;

  modport master (
    output alu_valid, alu_dest, alu_data, ld_issue, ld_issue_dest,
           ld_rsp_valid, ld_rsp_data,
    input  ld_issue_ready, ld_rsp_ready, reg_write_en, reg_write_dest,
           reg_write_data, pending, waw_err
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_issue, ld_issue_dest,
           ld_rsp_valid, ld_rsp_data,
    output ld_issue_ready, ld_rsp_ready, reg_write_en, reg_write_dest,
           reg_write_data, pending, waw_err
  );
endinterface

// File: rtl/wb_tag_fifo.sv
// In-order FIFO of outstanding load destinations; exposes every slot for the scoreboard.
module wb_tag_fifo
  import risc16_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [ADDR_W-1:0]              push_dest,
  input  logic                           pop,
  output logic [ADDR_W-1:0]              head,
  output logic [CNT_W-1:0]               count,
  output logic [DEPTH-1:0]               ent_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]   ent_dest
);
  logic [DEPTH-1:0][ADDR_W-1:0] mem;
  logic [PTR_W-1:0]             rd_ptr, wr_ptr;
  logic [CNT_W-1:0]             cnt;

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dest;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] off;
    assign off        = PTR_W'(i) - rd_ptr;
    assign ent_vld[i] = CNT_W'(off) < cnt;
  end

  assign ent_dest = mem;
  assign head     = mem[rd_ptr];
  assign count    = cnt;
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and in-order load data onto the regfile port.
module wb_arbiter
  import risc16_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic [ADDR_W-1:0]               head;
  logic [CNT_W-1:0]                cnt;
  logic [LQ_DEPTH-1:0]             ent_vld;
  logic [LQ_DEPTH-1:0][ADDR_W-1:0] ent_dest;

  logic          ready_en;
  wb_entry_t     hold_q, hold_d, out_q, out_d, ld_ent;
  logic          hold_vld, hold_vld_d, out_vld, out_vld_d;
  logic          waw_q;
  logic          issue_acc, rsp_acc;
  logic [NUM_REGS-1:0] pend;

  // ready_en keeps ld_issue_ready low while reset is asserted.
  assign bus.ld_issue_ready = ready_en && (cnt < CNT_W'(LQ_DEPTH));
  assign bus.ld_rsp_ready   = (cnt != '0) && !hold_vld;
  assign issue_acc          = bus.ld_issue && bus.ld_issue_ready;
  assign rsp_acc            = bus.ld_rsp_valid && bus.ld_rsp_ready;
  assign ld_ent             = '{dest: head, data: bus.ld_rsp_data, is_load: 1'b1};

  wb_tag_fifo #(.DEPTH(LQ_DEPTH)) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue_acc),
    .push_dest (bus.ld_issue_dest),
    .pop       (rsp_acc),
    .head      (head),
    .count     (cnt),
    .ent_vld   (ent_vld),
    .ent_dest  (ent_dest)
  );

  // ALU wins; a displaced load parks in hold and drains on the next ALU-free cycle.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = 1'b0;
    hold_d     = hold_q;
    hold_vld_d = hold_vld;
    if (bus.alu_valid) begin
      out_d     = '{dest: bus.alu_dest, data: bus.alu_data, is_load: 1'b0};
      out_vld_d = 1'b1;
      if (rsp_acc) begin
        hold_d     = ld_ent;
        hold_vld_d = 1'b1;
      end
    end else if (hold_vld) begin
      out_d      = hold_q;
      out_vld_d  = 1'b1;
      hold_vld_d = 1'b0;
    end else if (rsp_acc) begin
      out_d     = ld_ent;
      out_vld_d = 1'b1;
    end
  end

  always_comb begin
    pend = '0;
    for (int e = 0; e < LQ_DEPTH; e++)
      if (ent_vld[e]) pend[ent_dest[e]] = 1'b1;
    if (hold_vld) pend[hold_q.dest] = 1'b1;
    if (out_vld && out_q.is_load) pend[out_q.dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      hold_q   <= '0;
      hold_vld <= 1'b0;
      out_q    <= '0;
      out_vld  <= 1'b0;
      waw_q    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      hold_q   <= hold_d;
      hold_vld <= hold_vld_d;
      out_q    <= out_d;
      out_vld  <= out_vld_d;
      waw_q    <= waw_q | (bus.alu_valid && pend[bus.alu_dest]);
    end
  end

  assign bus.reg_write_en   = out_vld;
  assign bus.reg_write_dest = out_q.dest;
  assign bus.reg_write_data = out_q.data;
  assign bus.pending        = pend;
  assign bus.waw_err        = waw_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; a write-order scoreboard checks every regfile write.
module tb_wb_arbiter;
  import risc16_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] d;
    logic [DATA_W-1:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  wb_arbiter_if bus();

  wb_arbiter #(.LQ_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
    exp_t e;
    e.d = d;
    e.v = v;
    q.push_back(e);
  endtask

  // Every regfile write must match the next expected entry, in order.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n === 1'b1 && bus.reg_write_en === 1'b1) begin
      chk("wr_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_dest", 32'(bus.reg_write_dest), 32'(e.d));
        chk("wr_data", 32'(bus.reg_write_data), 32'(e.v));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n             = 1'b0;
    bus.alu_valid     = 1'b1;
    bus.alu_dest      = 3'd3;
    bus.alu_data      = 16'hFFFF;
    bus.ld_issue      = 1'b0;
    bus.ld_issue_dest = '0;
    bus.ld_rsp_valid  = 1'b0;
    bus.ld_rsp_data   = '0;

    // 1: reset with ALU valid held
    tick(); tick();
    chk("rst_outs", {31'd0, |{bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data,
        bus.pending, bus.waw_err, bus.ld_issue_ready, bus.ld_rsp_ready}}, 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.alu_valid = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.ld_issue_ready), 32'd1);
    chk("post_rst_pend", 32'(bus.pending), 32'd0);
    chk("post_rst_wen", 32'(bus.reg_write_en), 32'd0);

    // 2: single ALU write
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd3; bus.alu_data = 16'hBEEF;
    push_exp(3'd3, 16'hBEEF);
    tick();
    chk("alu_wen", 32'(bus.reg_write_en), 32'd1);
    chk("alu_pend", 32'(bus.pending), 32'd0);
    bus.alu_valid = 1'b0;
    tick();
    chk("alu_wen_once", 32'(bus.reg_write_en), 32'd0);

    // 3: load to r5, response 3 cycles after issue
    bus.ld_issue = 1'b1; bus.ld_issue_dest = 3'd5;
    tick();
    bus.ld_issue = 1'b0;
    chk("ld_pend_t1", 32'(bus.pending), 32'h20);
    chk("ld_rsp_rdy", 32'(bus.ld_rsp_ready), 32'd1);
    tick();
    chk("ld_pend_t2", 32'(bus.pending), 32'h20);
    tick();
    chk("ld_pend_t3", 32'(bus.pending), 32'h20);
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 16'h1234;
    push_exp(3'd5, 16'h1234);
    tick();
    bus.ld_rsp_valid = 1'b0;
    chk("ld_wen_t4", 32'(bus.reg_write_en), 32'd1);
    chk("ld_pend_t4", 32'(bus.pending), 32'h20);
    tick();
    chk("ld_pend_t5", 32'(bus.pending), 32'd0);
    chk("ld_wen_t5", 32'(bus.reg_write_en), 32'd0);

    // 4: fill the tag FIFO, over-issue, then drain in order
    bus.ld_issue = 1'b1; bus.ld_issue_dest = 3'd2;
    tick();
    bus.ld_issue_dest = 3'd6;
    tick();
    chk("full_ready", 32'(bus.ld_issue_ready), 32'd0);
    bus.ld_issue_dest = 3'd0;
    tick();
    bus.ld_issue = 1'b0;
    chk("full_ignored_pend", 32'(bus.pending), 32'h44);
    chk("full_ready2", 32'(bus.ld_issue_ready), 32'd0);
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 16'hAAAA;
    push_exp(3'd2, 16'hAAAA);
    tick();
    chk("ready_after_pop", 32'(bus.ld_issue_ready), 32'd1);
    chk("pend_after_pop", 32'(bus.pending), 32'h44);
    bus.ld_rsp_data = 16'hBBBB;
    push_exp(3'd6, 16'hBBBB);
    tick();
    bus.ld_rsp_valid = 1'b0;
    tick();
    chk("drain_pend", 32'(bus.pending), 32'd0);
    chk("drain_rsp_rdy", 32'(bus.ld_rsp_ready), 32'd0);

    // 5: load response collides with ALU; hold blocks further responses
    bus.ld_issue = 1'b1; bus.ld_issue_dest = 3'd1;
    tick();
    bus.ld_issue_dest = 3'd2;
    tick();
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd4; bus.alu_data = 16'h0AAA;
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 16'h00FF;
    push_exp(3'd4, 16'h0AAA);
    push_exp(3'd1, 16'h00FF);
    tick();
    chk("col_wen_t1", 32'(bus.reg_write_en), 32'd1);
    chk("col_rsp_rdy_t1", 32'(bus.ld_rsp_ready), 32'd0);
    chk("col_pend_t1", 32'(bus.pending), 32'h06);
    bus.alu_valid = 1'b0;
    bus.ld_rsp_data = 16'h2222;
    push_exp(3'd2, 16'h2222);
    tick();
    chk("col_wen_t2", 32'(bus.reg_write_en), 32'd1);
    chk("col_rsp_rdy_t2", 32'(bus.ld_rsp_ready), 32'd1);
    tick();
    bus.ld_rsp_valid = 1'b0;
    chk("col_wen_t3", 32'(bus.reg_write_en), 32'd1);
    tick();
    chk("col_pend_t4", 32'(bus.pending), 32'd0);
    chk("col_wen_t4", 32'(bus.reg_write_en), 32'd0);

    // 5b: ALU stays busy, load slips one more cycle
    bus.ld_issue = 1'b1; bus.ld_issue_dest = 3'd1;
    tick();
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd4; bus.alu_data = 16'h1111;
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 16'h0F0F;
    push_exp(3'd4, 16'h1111);
    tick();
    bus.ld_rsp_valid = 1'b0;
    bus.alu_dest = 3'd5; bus.alu_data = 16'h5555;
    push_exp(3'd5, 16'h5555);
    push_exp(3'd1, 16'h0F0F);
    tick();
    chk("slip_wen_t2", 32'(bus.reg_write_en), 32'd1);
    chk("slip_pend_t2", 32'(bus.pending), 32'h02);
    bus.alu_valid = 1'b0;
    tick();
    chk("slip_wen_t3", 32'(bus.reg_write_en), 32'd1);
    chk("slip_pend_t3", 32'(bus.pending), 32'h02);
    tick();
    chk("slip_pend_t4", 32'(bus.pending), 32'd0);
    chk("no_waw_yet", 32'(bus.waw_err), 32'd0);

    // 6: ALU writes a register with a pending load -> sticky waw_err
    bus.ld_issue = 1'b1; bus.ld_issue_dest = 3'd7;
    tick();
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dest = 3'd7; bus.alu_data = 16'h7777;
    push_exp(3'd7, 16'h7777);
    tick();
    bus.alu_valid = 1'b0;
    chk("waw_set", 32'(bus.waw_err), 32'd1);
    tick();
    chk("waw_sticky", 32'(bus.waw_err), 32'd1);
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 16'h7070;
    push_exp(3'd7, 16'h7070);
    tick();
    bus.ld_rsp_valid = 1'b0;
    tick();
    chk("waw_sticky2", 32'(bus.waw_err), 32'd1);
    bus.ld_issue = 1'b1; bus.ld_issue_dest = 3'd3;
    tick();
    bus.ld_issue = 1'b0;
    chk("pre_rst_pend", 32'(bus.pending), 32'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pend", 32'(bus.pending), 32'd0);
    chk("midrst_waw", 32'(bus.waw_err), 32'd0);
    chk("midrst_ready", 32'(bus.ld_issue_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rerst_ready", 32'(bus.ld_issue_ready), 32'd1);
    chk("rerst_rsp_rdy", 32'(bus.ld_rsp_ready), 32'd0);
    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
